// File: rtl/axi_addr_decode_tracker.sv
// -----------------------------------------------------------------------------
// axi_addr_decode_tracker
//
// Second stage of the two-master AXI interconnect. It sits behind the
// read/write grant arbiter, takes the one-hot stage-1 grant, latches the
// winning master's address, burst length, owner and direction, and decodes
// the target slave. It then drives the slave address handshake and follows
// the transaction to completion. While it does so it reports busy status
// back to the arbiter, which keeps the grant held.
//
// Build option:
//   DECERR_EN defined   - addresses are range-decoded into S0, S1 or the
//                         built-in default (decode-error) slave, which
//                         answers reads, writes and responses itself.
//   DECERR_EN undefined - ADDR bit 16 alone selects S0/S1. There is no
//                         default slave and the DEF_* outputs are tied low.
//
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   ARVALID_M_0stage1 / ARVALID_M_1stage1 / AWVALID_M_1stage1
//                                    one-hot grant from the arbiter
//   ARADDR_M0/M1, AWADDR_M1          master addresses
//   ARLEN_M0/M1, AWLEN_M1            master burst lengths (beats = LEN+1)
//   ARREADY_M0/M1, AWREADY_M1        address accept back to the masters
//   ARVALID_S0/S1, AWVALID_S0/S1     address valid to the slaves
//   ARREADY_S0/S1, AWREADY_S0/S1     address ready from the slaves
//   ARADDR_S/AWADDR_S, ARLEN_S/AWLEN_S  latched address and length
//   ARMASTER_S                       read owner (0=M0, 1=M1)
//   RVALID_Sx, RLAST_Sx, RREADY_M    read data return handshake
//   BVALID_Sx, BREADY_M1             write response handshake
//   WVALID_M1, WLAST_M1              M1 write data (consumed by DEF only)
//   DEF_RVALID/RLAST/WREADY/BVALID   default-slave handshake
//   rd_slave_sel, wr_slave_sel       0=S0, 1=S1, 2=DEF, 3=none
//   read_situation_decode            bit0 M0 read busy, bit1 M1 read busy
//   write_situation_decode           M1 write busy
// -----------------------------------------------------------------------------
module axi_addr_decode_tracker #(
    parameter int                ADDR_W   = 32,
    parameter int                LEN_W    = 4,
    parameter logic [ADDR_W-1:0] S0_BASE  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] S0_LIMIT = 32'h0000_FFFF,
    parameter logic [ADDR_W-1:0] S1_BASE  = 32'h0001_0000,
    parameter logic [ADDR_W-1:0] S1_LIMIT = 32'h0001_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ARVALID_M_0stage1,
    input  logic              ARVALID_M_1stage1,
    input  logic              AWVALID_M_1stage1,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [ADDR_W-1:0] AWADDR_M1,
    input  logic [LEN_W-1:0]  ARLEN_M0,
    input  logic [LEN_W-1:0]  ARLEN_M1,
    input  logic [LEN_W-1:0]  AWLEN_M1,
    output logic              ARREADY_M0,
    output logic              ARREADY_M1,
    output logic              AWREADY_M1,
    output logic              ARVALID_S0,
    output logic              ARVALID_S1,
    output logic              AWVALID_S0,
    output logic              AWVALID_S1,
    input  logic              ARREADY_S0,
    input  logic              ARREADY_S1,
    input  logic              AWREADY_S0,
    input  logic              AWREADY_S1,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [ADDR_W-1:0] AWADDR_S,
    output logic [LEN_W-1:0]  ARLEN_S,
    output logic [LEN_W-1:0]  AWLEN_S,
    output logic              ARMASTER_S,
    input  logic              RVALID_S0,
    input  logic              RVALID_S1,
    input  logic              RLAST_S0,
    input  logic              RLAST_S1,
    input  logic              RREADY_M,
    input  logic              BVALID_S0,
    input  logic              BVALID_S1,
    input  logic              BREADY_M1,
    input  logic              WVALID_M1,
    input  logic              WLAST_M1,
    output logic              DEF_RVALID,
    output logic              DEF_RLAST,
    output logic              DEF_WREADY,
    output logic              DEF_BVALID,
    output logic [1:0]        rd_slave_sel,
    output logic [1:0]        wr_slave_sel,
    output logic [1:0]        read_situation_decode,
    output logic              write_situation_decode
);

    localparam logic [1:0] SEL_S0   = 2'd0;
    localparam logic [1:0] SEL_S1   = 2'd1;
    localparam logic [1:0] SEL_DEF  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RDATA = 3'd2,
        WRESP = 3'd3,
        DONE  = 3'd4
`ifdef DECERR_EN
        , WDATA = 3'd5
`endif
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              isWrite_q;
    logic              owner_q;
    logic [1:0]        sel_q;
`ifdef DECERR_EN
    logic [LEN_W-1:0]  beatCnt_q;
`endif

    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W-1:0]  len_d;
    logic              isWrite_d;
    logic              owner_d;
    logic [1:0]        sel_d;
    logic              grantAny;

    // Grant mux. Only one grant bit should ever be high; if the arbiter
    // misbehaves, the write grant wins, then the M1 read, then the M0 read.
    always_comb begin
        addr_d    = ARADDR_M0;
        len_d     = ARLEN_M0;
        isWrite_d = 1'b0;
        owner_d   = 1'b0;
        if (AWVALID_M_1stage1) begin
            addr_d    = AWADDR_M1;
            len_d     = AWLEN_M1;
            isWrite_d = 1'b1;
            owner_d   = 1'b1;
        end else if (ARVALID_M_1stage1) begin
            addr_d    = ARADDR_M1;
            len_d     = ARLEN_M1;
            owner_d   = 1'b1;
        end
    end

    assign grantAny = ARVALID_M_0stage1 | ARVALID_M_1stage1 | AWVALID_M_1stage1;

`ifdef DECERR_EN
    // Inclusive range test done as (addr - base) <= (limit - base): the
    // unsigned wrap makes addresses below base fail without a >= compare.
    always_comb begin
        sel_d = SEL_DEF;
        if ((addr_d - S0_BASE) <= (S0_LIMIT - S0_BASE)) begin
            sel_d = SEL_S0;
        end else if ((addr_d - S1_BASE) <= (S1_LIMIT - S1_BASE)) begin
            sel_d = SEL_S1;
        end
    end
`else
    assign sel_d = addr_d[16] ? SEL_S1 : SEL_S0;

    logic unusedDefault;
    assign unusedDefault = ^{S0_BASE, S0_LIMIT, S1_BASE, S1_LIMIT, SEL_DEF,
                             WVALID_M1, WLAST_M1};
`endif

    logic arReadySel;
    logic awReadySel;
    logic rdDone;
    logic wrDone;
    logic addrHs;

    // Route the handshake of the latched target slave. The default slave
    // accepts the address at once and finishes from the master side alone.
    always_comb begin
        arReadySel = 1'b1;
        awReadySel = 1'b1;
        rdDone     = 1'b0;
        wrDone     = 1'b0;
        case (sel_q)
            SEL_S0: begin
                arReadySel = ARREADY_S0;
                awReadySel = AWREADY_S0;
                rdDone     = RVALID_S0 & RLAST_S0 & RREADY_M;
                wrDone     = BVALID_S0 & BREADY_M1;
            end
            SEL_S1: begin
                arReadySel = ARREADY_S1;
                awReadySel = AWREADY_S1;
                rdDone     = RVALID_S1 & RLAST_S1 & RREADY_M;
                wrDone     = BVALID_S1 & BREADY_M1;
            end
            default: begin
`ifdef DECERR_EN
                rdDone = RREADY_M & (beatCnt_q == len_q);
                wrDone = BREADY_M1;
`endif
            end
        endcase
    end

    assign addrHs = (state_q == ADDR) & (isWrite_q ? awReadySel : arReadySel);

    // Transaction tracker. DONE always burns one cycle so the arbiter's stale
    // registered grant is never mistaken for a new request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            isWrite_q <= 1'b0;
            owner_q   <= 1'b0;
            sel_q     <= '0;
`ifdef DECERR_EN
            beatCnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantAny) begin
                        addr_q    <= addr_d;
                        len_q     <= len_d;
                        isWrite_q <= isWrite_d;
                        owner_q   <= owner_d;
                        sel_q     <= sel_d;
`ifdef DECERR_EN
                        beatCnt_q <= '0;
`endif
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (addrHs) begin
                        if (!isWrite_q) begin
                            state_q <= RDATA;
`ifdef DECERR_EN
                        end else if (sel_q == SEL_DEF) begin
                            state_q <= WDATA;
`endif
                        end else begin
                            state_q <= WRESP;
                        end
                    end
                end
                RDATA: begin
                    if (rdDone) begin
                        state_q <= DONE;
`ifdef DECERR_EN
                    end else if ((sel_q == SEL_DEF) && RREADY_M) begin
                        beatCnt_q <= beatCnt_q + 1'b1;
`endif
                    end
                end
`ifdef DECERR_EN
                WDATA: begin
                    if (WVALID_M1 && WLAST_M1) begin
                        state_q <= WRESP;
                    end
                end
`endif
                WRESP: begin
                    if (wrDone) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic inAddr;
    logic active;

    assign inAddr = (state_q == ADDR);
    assign active = (state_q != IDLE) && (state_q != DONE);

    assign ARVALID_S0 = inAddr & ~isWrite_q & (sel_q == SEL_S0);
    assign ARVALID_S1 = inAddr & ~isWrite_q & (sel_q == SEL_S1);
    assign AWVALID_S0 = inAddr &  isWrite_q & (sel_q == SEL_S0);
    assign AWVALID_S1 = inAddr &  isWrite_q & (sel_q == SEL_S1);

    assign ARREADY_M0 = inAddr & ~isWrite_q & ~owner_q & arReadySel;
    assign ARREADY_M1 = inAddr & ~isWrite_q &  owner_q & arReadySel;
    assign AWREADY_M1 = inAddr &  isWrite_q & awReadySel;

    assign ARADDR_S   = isWrite_q ? '0 : addr_q;
    assign AWADDR_S   = isWrite_q ? addr_q : '0;
    assign ARLEN_S    = isWrite_q ? '0 : len_q;
    assign AWLEN_S    = isWrite_q ? len_q : '0;
    assign ARMASTER_S = ~isWrite_q & owner_q;

    assign read_situation_decode  = {active & ~isWrite_q & owner_q,
                                     active & ~isWrite_q & ~owner_q};
    assign write_situation_decode = active & isWrite_q;

    assign rd_slave_sel = (active & ~isWrite_q) ? sel_q : SEL_NONE;
    assign wr_slave_sel = (active &  isWrite_q) ? sel_q : SEL_NONE;

`ifdef DECERR_EN
    assign DEF_RVALID = (state_q == RDATA) && (sel_q == SEL_DEF);
    assign DEF_RLAST  = DEF_RVALID && (beatCnt_q == len_q);
    assign DEF_WREADY = (state_q == WDATA);
    assign DEF_BVALID = (state_q == WRESP) && (sel_q == SEL_DEF);
`else
    assign DEF_RVALID = 1'b0;
    assign DEF_RLAST  = 1'b0;
    assign DEF_WREADY = 1'b0;
    assign DEF_BVALID = 1'b0;
`endif

endmodule

// File: tb/tb_axi_addr_decode_tracker.sv
// -----------------------------------------------------------------------------
// tb_axi_addr_decode_tracker
//
// Self-checking bench for axi_addr_decode_tracker. Every grant pushes the
// expected latched transaction (target slave, owner, address, length) onto
// a scoreboard queue. The entry is popped and compared once the DUT enters
// its address phase. The data and response phases are then stepped cycle
// by cycle against the expected busy flags and default-slave handshake.
// With DECERR_EN defined, the expected slave comes from the range decode.
// Without it, the expected slave comes from address bit 16.
// -----------------------------------------------------------------------------
module tb_axi_addr_decode_tracker;

   localparam int KIND_AR_M0 = 0;
   localparam int KIND_AR_M1 = 1;
   localparam int KIND_AW_M1 = 2;

   typedef struct packed {
      logic        wr;
      logic        m1;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [1:0]  sel;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   logic ARVALID_M_0stage1, ARVALID_M_1stage1, AWVALID_M_1stage1;
   logic [31:0] ARADDR_M0, ARADDR_M1, AWADDR_M1;
   logic [3:0] ARLEN_M0, ARLEN_M1, AWLEN_M1;
   logic ARREADY_M0, ARREADY_M1, AWREADY_M1;
   logic ARVALID_S0, ARVALID_S1, AWVALID_S0, AWVALID_S1;
   logic ARREADY_S0, ARREADY_S1, AWREADY_S0, AWREADY_S1;
   logic [31:0] ARADDR_S, AWADDR_S;
   logic [3:0] ARLEN_S, AWLEN_S;
   logic ARMASTER_S;
   logic RVALID_S0, RVALID_S1, RLAST_S0, RLAST_S1, RREADY_M;
   logic BVALID_S0, BVALID_S1, BREADY_M1, WVALID_M1, WLAST_M1;
   logic DEF_RVALID, DEF_RLAST, DEF_WREADY, DEF_BVALID;
   logic [1:0] rd_slave_sel, wr_slave_sel, read_situation_decode;
   logic write_situation_decode;

   int checkCount = 0;
   int failCount = 0;
   txn_t expQ[$];
   txn_t cur;
   bit holdGrant = 0;

   axi_addr_decode_tracker dut (
      .clk(clk), .rst(rst),
      .ARVALID_M_0stage1(ARVALID_M_0stage1), .ARVALID_M_1stage1(ARVALID_M_1stage1),
      .AWVALID_M_1stage1(AWVALID_M_1stage1),
      .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1), .AWADDR_M1(AWADDR_M1),
      .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1), .AWLEN_M1(AWLEN_M1),
      .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1), .AWREADY_M1(AWREADY_M1),
      .ARVALID_S0(ARVALID_S0), .ARVALID_S1(ARVALID_S1),
      .AWVALID_S0(AWVALID_S0), .AWVALID_S1(AWVALID_S1),
      .ARREADY_S0(ARREADY_S0), .ARREADY_S1(ARREADY_S1),
      .AWREADY_S0(AWREADY_S0), .AWREADY_S1(AWREADY_S1),
      .ARADDR_S(ARADDR_S), .AWADDR_S(AWADDR_S), .ARLEN_S(ARLEN_S), .AWLEN_S(AWLEN_S),
      .ARMASTER_S(ARMASTER_S),
      .RVALID_S0(RVALID_S0), .RVALID_S1(RVALID_S1), .RLAST_S0(RLAST_S0), .RLAST_S1(RLAST_S1),
      .RREADY_M(RREADY_M),
      .BVALID_S0(BVALID_S0), .BVALID_S1(BVALID_S1), .BREADY_M1(BREADY_M1),
      .WVALID_M1(WVALID_M1), .WLAST_M1(WLAST_M1),
      .DEF_RVALID(DEF_RVALID), .DEF_RLAST(DEF_RLAST), .DEF_WREADY(DEF_WREADY),
      .DEF_BVALID(DEF_BVALID),
      .rd_slave_sel(rd_slave_sel), .wr_slave_sel(wr_slave_sel),
      .read_situation_decode(read_situation_decode),
      .write_situation_decode(write_situation_decode)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Hard stop in case something stalls the stimulus sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reference decode of the target slave from the address.
   function automatic logic [1:0] modelSel(input logic [31:0] a);
`ifdef DECERR_EN
      if (a <= 32'h0000_FFFF) return 2'd0;
      if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 2'd1;
      return 2'd2;
`else
      return a[16] ? 2'd1 : 2'd0;
`endif
   endfunction

   function automatic logic anyValid();
      return ARVALID_S0 | ARVALID_S1 | AWVALID_S0 | AWVALID_S1;
   endfunction

   function automatic logic slaveValid(input txn_t t);
      case ({t.wr, t.sel})
         3'b000:  return ARVALID_S0;
         3'b001:  return ARVALID_S1;
         3'b100:  return AWVALID_S0;
         3'b101:  return AWVALID_S1;
         default: return anyValid();
      endcase
   endfunction

   function automatic logic masterReady(input txn_t t);
      if (t.wr) return AWREADY_M1;
      return t.m1 ? ARREADY_M1 : ARREADY_M0;
   endfunction

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearGrants();
      ARVALID_M_0stage1 = 1'b0;
      ARVALID_M_1stage1 = 1'b0;
      AWVALID_M_1stage1 = 1'b0;
   endtask

   task automatic clearAll();
      clearGrants();
      ARADDR_M0 = '0; ARADDR_M1 = '0; AWADDR_M1 = '0;
      ARLEN_M0 = '0; ARLEN_M1 = '0; AWLEN_M1 = '0;
      ARREADY_S0 = 0; ARREADY_S1 = 0; AWREADY_S0 = 0; AWREADY_S1 = 0;
      RVALID_S0 = 0; RVALID_S1 = 0; RLAST_S0 = 0; RLAST_S1 = 0; RREADY_M = 0;
      BVALID_S0 = 0; BVALID_S1 = 0; BREADY_M1 = 0; WVALID_M1 = 0; WLAST_M1 = 0;
   endtask

   task automatic setSlaveReady(input txn_t t, input logic v);
      case ({t.wr, t.sel})
         3'b000:  ARREADY_S0 = v;
         3'b001:  ARREADY_S1 = v;
         3'b100:  AWREADY_S0 = v;
         3'b101:  AWREADY_S1 = v;
         default: ;
      endcase
   endtask

   task automatic driveR(input logic [1:0] sel, input logic v, input logic last);
      RVALID_S0 = (sel == 2'd0) & v;
      RLAST_S0  = (sel == 2'd0) & last;
      RVALID_S1 = (sel == 2'd1) & v;
      RLAST_S1  = (sel == 2'd1) & last;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_busy"}, {read_situation_decode, write_situation_decode}, 3'b000);
      checkOutput({tag, "_sel"}, {rd_slave_sel, wr_slave_sel}, 4'hF);
      checkOutput({tag, "_valids"}, {ARVALID_S0, ARVALID_S1, AWVALID_S0, AWVALID_S1}, 4'h0);
      checkOutput({tag, "_readies"}, {ARREADY_M0, ARREADY_M1, AWREADY_M1}, 3'b000);
      checkOutput({tag, "_def"}, {DEF_RVALID, DEF_RLAST, DEF_WREADY, DEF_BVALID}, 4'h0);
      checkOutput({tag, "_addr"}, {ARADDR_S, AWADDR_S}, 64'h0);
      checkOutput({tag, "_len_owner"}, {ARLEN_S, AWLEN_S, ARMASTER_S}, 9'h0);
   endtask

   // Check the DONE cycle, then the following cycle, which must be IDLE.
   // The stale grant is dropped only once IDLE is reached.
   task automatic checkDone(input string tag);
      checkOutput({tag, "_done_busy"}, {read_situation_decode, write_situation_decode}, 3'b000);
      checkOutput({tag, "_done_sel"}, {rd_slave_sel, wr_slave_sel}, 4'hF);
      checkOutput({tag, "_done_valid"}, anyValid(), 1'b0);
      checkOutput({tag, "_done_def"}, {DEF_RVALID, DEF_RLAST, DEF_WREADY, DEF_BVALID}, 4'h0);
      nextCycle();
      clearGrants();
      #1;
      checkOutput({tag, "_idle_busy"}, {read_situation_decode, write_situation_decode}, 3'b000);
   endtask

   // Present one grant during an IDLE cycle and record what the DUT must latch.
   task automatic applyStimulus(input int kind, input logic [31:0] a, input logic [3:0] l);
      txn_t t;
      t.wr = (kind == KIND_AW_M1);
      t.m1 = (kind != KIND_AR_M0);
      t.addr = a;
      t.len = l;
      t.sel = modelSel(a);
      expQ.push_back(t);
      case (kind)
         KIND_AR_M0: begin ARVALID_M_0stage1 = 1; ARADDR_M0 = a; ARLEN_M0 = l; end
         KIND_AR_M1: begin ARVALID_M_1stage1 = 1; ARADDR_M1 = a; ARLEN_M1 = l; end
         default:    begin AWVALID_M_1stage1 = 1; AWADDR_M1 = a; AWLEN_M1 = l; end
      endcase
      #1;
      checkOutput("pre_grant_busy", {read_situation_decode, write_situation_decode}, 3'b000);
      nextCycle();
   endtask

   // Address phase: pop the scoreboard entry, then complete the address
   // handshake after readyDelay wait cycles.
   task automatic addrPhase(input int readyDelay);
      if (!holdGrant) clearGrants();
      #1;
      if (expQ.size() == 0) begin
         checkOutput("sb_underflow", 1, 0);
         return;
      end
      cur = expQ.pop_front();
      checkOutput("addr_rd_busy", read_situation_decode, cur.wr ? 2'b00 : (cur.m1 ? 2'b10 : 2'b01));
      checkOutput("addr_wr_busy", write_situation_decode, cur.wr);
      if (cur.wr) begin
         checkOutput("addr_wr_sel", {rd_slave_sel, wr_slave_sel}, {2'd3, cur.sel});
         checkOutput("awaddr", AWADDR_S, cur.addr);
         checkOutput("awlen", AWLEN_S, cur.len);
      end else begin
         checkOutput("addr_rd_sel", {rd_slave_sel, wr_slave_sel}, {cur.sel, 2'd3});
         checkOutput("araddr", ARADDR_S, cur.addr);
         checkOutput("arlen", ARLEN_S, cur.len);
         checkOutput("armaster", ARMASTER_S, cur.m1);
      end
      if (cur.sel == 2'd2) begin
         checkOutput("def_addr_ready", masterReady(cur), 1'b1);
         checkOutput("def_addr_novalid", anyValid(), 1'b0);
      end else begin
         for (int i = 0; i < readyDelay; i++) begin
            checkOutput("s_valid_wait", slaveValid(cur), 1'b1);
            checkOutput("m_ready_wait", masterReady(cur), 1'b0);
            nextCycle();
         end
         setSlaveReady(cur, 1'b1);
         #1;
         checkOutput("s_valid_hs", slaveValid(cur), 1'b1);
         checkOutput("m_ready_hs", masterReady(cur), 1'b1);
      end
      nextCycle();
      setSlaveReady(cur, 1'b0);
      #1;
      checkOutput("valid_dropped", anyValid(), 1'b0);
   endtask

   // Read data phase: readyPat bit i is RREADY_M in the i-th RDATA cycle.
   task automatic readPhase(input logic [31:0] readyPat);
      int beat = 0;
      bit finished = 0;
      for (int i = 0; i < 32 && !finished; i++) begin
         RREADY_M = readyPat[i];
         driveR(cur.sel, 1'b1, beat == cur.len);
         #1;
         checkOutput("rd_busy", read_situation_decode, cur.m1 ? 2'b10 : 2'b01);
         checkOutput("rd_sel_data", rd_slave_sel, cur.sel);
         checkOutput("def_rvalid", DEF_RVALID, cur.sel == 2'd2);
         checkOutput("def_rlast", DEF_RLAST, (cur.sel == 2'd2) && (beat == cur.len));
         if (readyPat[i]) begin
            if (beat == cur.len) finished = 1;
            else beat++;
         end
         nextCycle();
      end
      RREADY_M = 0;
      driveR(cur.sel, 1'b0, 1'b0);
      #1;
      checkDone("rd");
   endtask

   // Write data (default slave only) and response phase; the response
   // waits respDelay cycles with BREADY_M1 low.
   task automatic writePhase(input int respDelay);
      if (cur.sel == 2'd2) begin
         for (int b = 0; b <= int'(cur.len); b++) begin
            WVALID_M1 = 1;
            WLAST_M1 = (b == int'(cur.len));
            #1;
            checkOutput("def_wready", DEF_WREADY, 1'b1);
            checkOutput("wdata_busy", write_situation_decode, 1'b1);
            nextCycle();
         end
         WVALID_M1 = 0;
         WLAST_M1 = 0;
      end
      BVALID_S0 = (cur.sel == 2'd0);
      BVALID_S1 = (cur.sel == 2'd1);
      for (int i = 0; i < respDelay; i++) begin
         BREADY_M1 = 0;
         #1;
         checkOutput("wresp_busy", write_situation_decode, 1'b1);
         checkOutput("def_bvalid_hold", DEF_BVALID, cur.sel == 2'd2);
         nextCycle();
      end
      BREADY_M1 = 1;
      #1;
      checkOutput("wresp_busy_hs", write_situation_decode, 1'b1);
      checkOutput("def_bvalid_hs", DEF_BVALID, cur.sel == 2'd2);
      nextCycle();
      BREADY_M1 = 0;
      BVALID_S0 = 0;
      BVALID_S1 = 0;
      #1;
      checkDone("wr");
   endtask

   // Directed sequence following the test plan.
   initial begin
      rst = 1'b0;
      clearAll();
      #1;
      checkReset("reset");
      repeat (2) nextCycle();
      rst = 1'b1;
      nextCycle();
      checkReset("post_reset");

      $display("[TB] AR_M0 read to S0, LEN=3, slave ready one cycle late");
      applyStimulus(KIND_AR_M0, 32'h0000_0100, 4'd3);
      addrPhase(1);
      readPhase(32'h0000_000F);

      $display("[TB] AW_M1 write to S1 region");
      applyStimulus(KIND_AW_M1, 32'h0001_0040, 4'd0);
      addrPhase(0);
      writePhase(2);

      $display("[TB] AR_M1 read to 0x0002_0000, LEN=2, RREADY 1,0,1,1");
      applyStimulus(KIND_AR_M1, 32'h0002_0000, 4'd2);
      addrPhase(0);
      readPhase(32'h0000_000D);

      $display("[TB] AW_M1 write to 0x0003_0000, LEN=1");
      applyStimulus(KIND_AW_M1, 32'h0003_0000, 4'd1);
      addrPhase(1);
      writePhase(2);

      $display("[TB] LEN=15 read with the grant held stale through DONE");
      holdGrant = 1;
      applyStimulus(KIND_AR_M0, 32'h0004_0000, 4'd15);
      addrPhase(0);
      readPhase(32'h0000_FFFF);
      holdGrant = 0;
      nextCycle();
      checkOutput("no_relaunch", {read_situation_decode, write_situation_decode}, 3'b000);
      applyStimulus(KIND_AR_M1, 32'h0001_8000, 4'd0);
      addrPhase(0);
      readPhase(32'h0000_0001);

      $display("[TB] reset pulsed during the second read beat");
      applyStimulus(KIND_AR_M0, 32'h0002_0000, 4'd3);
      addrPhase(0);
      RREADY_M = 1;
      driveR(cur.sel, 1'b1, 1'b0);
      nextCycle();
      #1;
      rst = 1'b0;
      #1;
      checkReset("rst_mid");
      clearAll();
      nextCycle();
      rst = 1'b1;
      nextCycle();
      checkReset("rst_release");
      applyStimulus(KIND_AR_M0, 32'h0002_0000, 4'd0);
      addrPhase(0);
      readPhase(32'h0000_0001);

      checkOutput("sb_drained", expQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
